// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches a variable-length instruction (opcode plus
// operand bytes) from byte-wide program memory, packs it MSB-first into one
// wide word and offers it to the decoder over a start/ready handshake.
// A jump redirect overrides everything except reset.
module instr_fetch_unit #(
    parameter int BYTE       = 8,
    parameter int MAX_BYTES  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_BITS   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           jump_valid,
    input  logic [ADDR_WIDTH-1:0]          jump_addr,
    output logic [ADDR_WIDTH-1:0]          pointer_for_memory,
    output logic                           read_en_for_memory,
    input  logic [BYTE-1:0]                data_from_memory,
    output logic                           start_for_decoder,
    input  logic                           ready_from_decoder,
    output logic [MAX_BYTES*BYTE-1:0]      data_for_decoder,
    output logic [$clog2(MAX_BYTES):0]     length_for_decoder,
    output logic                           len_error
);

    // Byte-slot index width and the largest legal operand count.
    localparam int KW    = $clog2(MAX_BYTES);
    localparam int LW    = KW + 1;
    localparam int MAX_N = MAX_BYTES - 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        SEND
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [KW-1:0]           k;        // slot being fetched, 0 = opcode
    logic [KW-1:0]           n_q;      // operand count of the current instruction
    logic [LEN_BITS-1:0]     opcode_len;
    logic [KW-1:0]           n_eff;    // operand count valid in this CAPTURE cycle
    logic                    clamp_now;

    // The address register doubles as the memory pointer output.
    assign pointer_for_memory = pc;
    assign opcode_len         = data_from_memory[LEN_BITS-1:0];

    // Operand count: taken from the opcode on slot 0, held afterwards; an
    // out-of-range length field is clamped to the widest instruction.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        clamp_now = 1'b0;
        n_eff     = n_q;
        if (k == '0) begin
            if (32'(opcode_len) > 32'(MAX_N)) begin
                clamp_now = 1'b1;
                n_eff     = KW'(MAX_N);
            end else begin
                n_eff     = KW'(opcode_len);
            end
        end
    end

    // Fetch sequencer with registered memory and decoder outputs.
    // NOTE: reset is asynchronous, so it clears every register (and drops
    // start_for_decoder) as soon as it is asserted, without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            pc                 <= '0;
            k                  <= '0;
            n_q                <= '0;
            read_en_for_memory <= 1'b0;
            start_for_decoder  <= 1'b0;
            data_for_decoder   <= '0;
            length_for_decoder <= '0;
            len_error          <= 1'b0;
        end else if (jump_valid) begin
            // NOTE: all sequential state uses non-blocking assignments so
            // every register sees the pre-edge values of the others.
            // A redirect discards any partial or pending word, including one
            // the decoder is accepting in this very cycle.
            pc                <= jump_addr;
            k                 <= '0;
            data_for_decoder  <= '0;
            start_for_decoder <= 1'b0;
            if (enable) begin
                state              <= ISSUE;
                read_en_for_memory <= 1'b1;
            end else begin
                state              <= IDLE;
                read_en_for_memory <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state              <= ISSUE;
                        read_en_for_memory <= 1'b1;
                    end
                end
                ISSUE: begin
                    read_en_for_memory <= 1'b0;
                    state              <= CAPTURE;
                end
                CAPTURE: begin
                    data_for_decoder[(MAX_N - int'(k)) * BYTE +: BYTE] <= data_from_memory;
                    pc  <= pc + ADDR_WIDTH'(1);
                    n_q <= n_eff;
                    if (clamp_now) begin
                        len_error <= 1'b1;
                    end
                    if (k < n_eff) begin
                        k                  <= k + KW'(1);
                        state              <= ISSUE;
                        read_en_for_memory <= 1'b1;
                    end else begin
                        state              <= SEND;
                        start_for_decoder  <= 1'b1;
                        length_for_decoder <= LW'(n_eff) + LW'(1);
                    end
                end
                SEND: begin
                    if (ready_from_decoder) begin
                        start_for_decoder <= 1'b0;
                        k                 <= '0;
                        data_for_decoder  <= '0;
                        if (enable) begin
                            state              <= ISSUE;
                            read_en_for_memory <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus a randomized run of
// instr_fetch_unit, checked against an instruction-level model that rebuilds
// each expected word straight from the memory image and the fetch address.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        jump_valid;
    logic [7:0]  jump_addr;
    logic [7:0]  ptr;
    logic        rd;
    logic [7:0]  din;
    logic        start;
    logic        ready;
    logic [31:0] dout;
    logic [2:0]  len;
    logic        lerr;

    // Second instance with two-byte instructions to exercise length clamping.
    logic        reset2;
    logic        enable2;
    logic        jump2;
    logic [7:0]  jump_addr2;
    logic [7:0]  ptr2;
    logic        rd2;
    logic [7:0]  din2;
    logic        start2;
    logic        ready2;
    logic [15:0] dout2;
    logic [1:0]  len2;
    logic        lerr2;

    logic [7:0]  mem [256];

    int n_checks = 0;
    int n_pass   = 0;
    int accepts  = 0;
    bit mon_on   = 1'b0;
    logic [7:0] exp_pc;

    always #5 clk = ~clk;

    instr_fetch_unit u_dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .jump_valid         (jump_valid),
        .jump_addr          (jump_addr),
        .pointer_for_memory (ptr),
        .read_en_for_memory (rd),
        .data_from_memory   (din),
        .start_for_decoder  (start),
        .ready_from_decoder (ready),
        .data_for_decoder   (dout),
        .length_for_decoder (len),
        .len_error          (lerr)
    );

    instr_fetch_unit #(.MAX_BYTES(2)) u_dut2 (
        .clk                (clk),
        .reset              (reset2),
        .enable             (enable2),
        .jump_valid         (jump2),
        .jump_addr          (jump_addr2),
        .pointer_for_memory (ptr2),
        .read_en_for_memory (rd2),
        .data_from_memory   (din2),
        .start_for_decoder  (start2),
        .ready_from_decoder (ready2),
        .data_for_decoder   (dout2),
        .length_for_decoder (len2),
        .len_error          (lerr2)
    );

    // Program memory: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        din  <= rd  ? mem[ptr]  : 8'($urandom);
        din2 <= rd2 ? mem[ptr2] : 8'($urandom);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for_start(output int cycles);
        cycles = 0;
        while (!start && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic wait_for_start2(output int cycles);
        cycles = 0;
        while (!start2 && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    // Expected packed word for a 4-byte-max fetcher starting at addr.
    task automatic model_word(input logic [7:0] addr, output logic [31:0] w, output int l);
        logic [7:0] op;
        logic [7:0] a;
        int n;
        op = mem[addr];
        n  = int'(op[1:0]);
        if (n > 3) n = 3;
        w = '0;
        for (int i = 0; i <= n; i++) begin
            a = addr + 8'(i);
            w = w | (32'(mem[a]) << (8 * (3 - i)));
        end
        l = n + 1;
    endtask

    // Scoreboard: a word is consumed whenever start and ready meet without
    // a jump; a jump moves the next fetch address to the jump target.
    always @(negedge clk) begin
        logic [31:0] w;
        int l;
        if (mon_on) begin
            if (start && ready && !jump_valid) begin
                model_word(exp_pc, w, l);
                check("rnd_data", 64'(dout), 64'(w));
                check("rnd_len", 64'(len), 64'(l));
                check("rnd_lerr", 64'(lerr), 64'(0));
                exp_pc = exp_pc + 8'(l);
                accepts++;
            end
            if (jump_valid) exp_pc = jump_addr;
        end
    end

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1; enable = 1'b0; jump_valid = 1'b0; jump_addr = '0; ready = 1'b0;
        reset2 = 1'b1; enable2 = 1'b0; jump2 = 1'b0; jump_addr2 = '0; ready2 = 1'b0;
        #2;

        // Reset state.
        check("rst_ptr", 64'(ptr), 64'(0));
        check("rst_rd", 64'(rd), 64'(0));
        check("rst_start", 64'(start), 64'(0));
        check("rst_data", 64'(dout), 64'(0));
        check("rst_len", 64'(len), 64'(0));
        check("rst_lerr", 64'(lerr), 64'(0));

        // Three-byte instruction: 2N cycles from ISSUE to start.
        mem[0] = 8'h02; mem[1] = 8'hAA; mem[2] = 8'hBB;
        enable = 1'b1; ready = 1'b1;
        tick();
        reset = 1'b0;
        wait_for_start(cyc);
        check("t3_cycles", 64'(cyc), 64'(7));
        check("t3_data", 64'(dout), 64'h02AABB00);
        check("t3_len", 64'(len), 64'(3));
        check("t3_pc", 64'(ptr), 64'(3));
        tick();
        check("t3_next_rd", 64'(rd), 64'(1));
        check("t3_next_ptr", 64'(ptr), 64'(3));
        check("t3_start_drop", 64'(start), 64'(0));

        // One-byte instruction held while the decoder stalls.
        reset = 1'b1;
        #1;
        mem[0] = 8'h40; ready = 1'b0;
        tick();
        reset = 1'b0;
        wait_for_start(cyc);
        check("t1_len", 64'(len), 64'(1));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_hold", 64'({start, dout}), {31'd0, 1'b1, 32'h40000000});
        end
        ready = 1'b1;
        tick();
        check("t1_acc_start", 64'(start), 64'(0));
        check("t1_acc_rd", 64'(rd), 64'(1));
        check("t1_acc_ptr", 64'(ptr), 64'(1));

        // Instruction straddling the address wrap, reached by a jump.
        reset = 1'b1;
        #1;
        mem[8'hFF] = 8'h01; mem[0] = 8'h5C; ready = 1'b0;
        mem[8'h10] = 8'h41; mem[8'h11] = 8'h99;
        tick();
        reset = 1'b0; jump_valid = 1'b1; jump_addr = 8'hFF;
        tick();
        jump_valid = 1'b0;
        check("wrap_ptr0", 64'(ptr), 64'hFF);
        wait_for_start(cyc);
        check("wrap_data", 64'(dout), 64'h015C0000);
        check("wrap_len", 64'(len), 64'(2));
        check("wrap_pc", 64'(ptr), 64'h01);

        // Jump in the same cycle as acceptance discards the word.
        ready = 1'b1; jump_valid = 1'b1; jump_addr = 8'h10;
        tick();
        jump_valid = 1'b0;
        check("jmp_start", 64'(start), 64'(0));
        check("jmp_rd", 64'(rd), 64'(1));
        check("jmp_ptr", 64'(ptr), 64'h10);
        check("jmp_data_clr", 64'(dout), 64'(0));
        wait_for_start(cyc);
        check("jmp_new_data", 64'(dout), 64'h41990000);

        // Asynchronous reset while operand 2 is being captured.
        reset = 1'b1;
        #1;
        mem[0] = 8'h03; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33;
        tick();
        reset = 1'b0;
        cyc = 0;
        while (!(rd && ptr == 8'd2) && cyc < 100) begin
            tick();
            cyc++;
        end
        tick();
        check("ar_partial", 64'(dout), 64'h03110000);
        #2;
        reset = 1'b1;
        #1;
        check("ar_ptr", 64'(ptr), 64'(0));
        check("ar_rd", 64'(rd), 64'(0));
        check("ar_start", 64'(start), 64'(0));
        check("ar_data", 64'(dout), 64'(0));
        check("ar_len", 64'(len), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        while (!rd && cyc < 100) begin
            tick();
            cyc++;
        end
        check("ar_restart_rd", 64'(rd), 64'(1));
        check("ar_restart_ptr", 64'(ptr), 64'(0));

        // Clamped length field on the two-byte instance; flag is sticky.
        reset = 1'b1;
        mem[0] = 8'h03; mem[1] = 8'hAA; mem[2] = 8'h01; mem[3] = 8'h77;
        check("cl_rst_lerr", 64'(lerr2), 64'(0));
        enable2 = 1'b1;
        tick();
        reset2 = 1'b0;
        wait_for_start2(cyc);
        check("cl_data", 64'(dout2), 64'h03AA);
        check("cl_len", 64'(len2), 64'(2));
        check("cl_lerr", 64'(lerr2), 64'(1));
        ready2 = 1'b1;
        tick();
        check("cl_next_ptr", 64'(ptr2), 64'(2));
        wait_for_start2(cyc);
        check("cl2_data", 64'(dout2), 64'h0177);
        check("cl2_len", 64'(len2), 64'(2));
        check("cl2_lerr_sticky", 64'(lerr2), 64'(1));
        reset2 = 1'b1;
        #1;
        check("cl_lerr_reset", 64'(lerr2), 64'(0));

        // Randomized run against the instruction-level model.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        tick();
        exp_pc = '0;
        reset  = 1'b0;
        mon_on = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            enable     = ($urandom_range(0, 9) != 0);
            ready      = ($urandom_range(0, 1) == 1);
            jump_valid = ($urandom_range(0, 39) == 0);
            jump_addr  = 8'($urandom);
            tick();
        end
        jump_valid = 1'b0;
        @(negedge clk);
        mon_on = 1'b0;
        check("rnd_progress", 64'(accepts > 100), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Parametrised instruction fetcher between program memory and the instruction decoder. It reads a 1-byte opcode, derives the operand count from a length field inside the opcode, and reads that many operand bytes. It packs the opcode and operands into one wide word and hands the word to the decoder over a start/ready handshake. It also supports a jump redirect and a pause input, and flags malformed length fields.

## Interface
- BYTE, 8: width of one memory word.
- MAX_BYTES, 4: maximum instruction length in bytes, opcode included; range 2..8.
- ADDR_WIDTH, 8: memory address width.
- LEN_BITS, 2: width of the operand-count field, located at opcode[LEN_BITS-1:0].
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- enable  input  1  when low, no new fetch begins; a fetch already in progress completes.
- jump_valid  input  1  one-cycle redirect request.
- jump_addr  input  ADDR_WIDTH  redirect target.
- pointer_for_memory  output  ADDR_WIDTH  read address.
- read_en_for_memory  output  1  read strobe.
- data_from_memory  input  BYTE  read data, valid exactly 1 cycle after the strobe.
- start_for_decoder  output  1  high while the packed instruction is valid.
- ready_from_decoder  input  1  decoder accepts the word in any cycle where start and ready are both high.
- data_for_decoder  output  MAX_BYTES*BYTE  packed instruction.
- length_for_decoder  output  $clog2(MAX_BYTES)+1  total bytes in the word (1..MAX_BYTES).
- len_error  output  1  sticky flag; set when a length field was clamped.

## Operation
- States: IDLE, ISSUE, CAPTURE, SEND.
- IDLE: if enable=1, go to ISSUE; otherwise remain.
- ISSUE:
  - Drive read_en_for_memory=1 and pointer_for_memory=pc.
  - Go to CAPTURE.
- CAPTURE:
  - Latch data_from_memory into byte slot k; increment pc.
  - Slot 0 (the opcode) goes to data[MAX_BYTES*BYTE-1 -: BYTE]. Each later slot sits BYTE bits lower. Unused low slots are zero.
  - At k=0, operand count n = opcode[LEN_BITS-1:0].
  - If n > MAX_BYTES-1: clamp n to MAX_BYTES-1 and set len_error.
  - If k < n, return to ISSUE with k+1. Otherwise go to SEND.
- SEND:
  - Hold start_for_decoder=1, data_for_decoder and length_for_decoder=n+1 stable until ready_from_decoder=1.
  - On acceptance: if enable=1, go to ISSUE; otherwise go to IDLE. Clear k and the data register.
- pc is ADDR_WIDTH bits and wraps from 2^ADDR_WIDTH-1 to 0. An instruction may straddle the wrap.
- Jump, in any state:
  - jump_valid=1 loads pc=jump_addr, clears k and data, drops start_for_decoder, and moves to ISSUE (IDLE if enable=0) on the next edge.
  - A word in SEND is discarded, even if ready_from_decoder=1 in the same cycle: jump wins.
  - A memory byte returning in that cycle is dropped.
- len_error clears only on reset.

## Timing
- Reset values:
  - state=IDLE, pc=0, k=0.
  - pointer_for_memory=0, read_en_for_memory=0.
  - start_for_decoder=0, data_for_decoder=0, length_for_decoder=0, len_error=0.
- Outputs are registered. read_en_for_memory is high only in ISSUE. start_for_decoder is high only in SEND.
- An N-byte instruction takes 2N cycles from entering ISSUE to start_for_decoder rising.
- With ready_from_decoder held high, consecutive instructions need 2N+1 cycles each: one cycle in SEND, then ISSUE next.
- Reset asserted mid-fetch or mid-SEND aborts immediately and drops start_for_decoder without waiting for a clock edge. After release, fetching restarts at address 0.
- enable low during ISSUE/CAPTURE does not stall the fetch; it is sampled only in IDLE and at SEND acceptance.

## Test plan
- Defaults, mem[0]=0x02, mem[1]=0xAA, mem[2]=0xBB, enable=1, ready=1 -> after 6 cycles, start=1, data_for_decoder=0x02AABB00, length_for_decoder=3, pc=3.
- 1-byte opcode 0x40 at addr 0, ready low for 5 cycles -> start stays high and data is stable at 0x40000000; accepted on the cycle ready rises; next fetch is from addr 1.
- MAX_BYTES=2, opcode 0x03 -> n clamped to 1, len_error=1, length_for_decoder=2; len_error persists over later instructions.
- pc=0xFF, opcode 0x01 at 0xFF, operand 0x5C at 0x00 -> data_for_decoder=0x015C0000, pc wraps to 0x01.
- jump_valid with jump_addr=0x10 in the same cycle as a SEND acceptance -> word discarded (no handshake completes), next read_en_for_memory at address 0x10.
- Reset pulsed asynchronously during CAPTURE of operand 2 -> all outputs return to reset values before the next edge; after release the first read is at address 0.
